// File: rtl/arcade_input_pkg.sv
// Shared direction indices, rank type and rotation helper for the arcade input conditioner.
package arcade_input_pkg;

  localparam int unsigned DIR_UP    = 3;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_RIGHT = 0;

  typedef logic [1:0] rank_t;

  // Quarter-turn remap: up<-left, down<-right, left<-down, right<-up.
  function automatic logic [3:0] rot90(input logic [3:0] dir4);
    logic [3:0] r;
    r[DIR_UP]    = dir4[DIR_LEFT];
    r[DIR_DOWN]  = dir4[DIR_RIGHT];
    r[DIR_LEFT]  = dir4[DIR_DOWN];
    r[DIR_RIGHT] = dir4[DIR_UP];
    return r;
  endfunction

endpackage

// File: rtl/joy_dir_prio.sv
// One player's press-recency ranking and 4-way / 8-way direction resolution.
module joy_dir_prio
  import arcade_input_pkg::*;
(
  input  logic       clk,
  input  logic       RESET,
  input  logic [3:0] stable,
  input  logic       mode_8way,
  output logic [3:0] dir,
  output logic       active
);

  rank_t      rank_q [4];
  rank_t      rank_d [4];
  logic [3:0] prev_q;
  logic [3:0] rise;
  logic [3:0] dir_d;
  logic [3:0] dir_q;
  logic       active_q;
  logic       found;
  rank_t      best;
  logic [2:0] n;

  always_comb begin
    rise  = stable & ~prev_q;
    n     = '0;
    found = 1'b0;
    best  = '0;
    // Rising dirs take the top ranks (up first); the rest keep relative order below them.
    for (int d = 0; d < 4; d++) begin
      n = '0;
      for (int e = 0; e < 4; e++) begin
        if (rise[d]) begin
          if (rise[e] && e > d) n = n + 3'd1;
        end else if (!rise[e] && rank_q[e] < rank_q[d]) begin
          n = n + 3'd1;
        end
      end
      rank_d[d] = rise[d] ? 2'(3'd3 - n) : 2'(n);
    end

    dir_d = '0;
    if (mode_8way) begin
      dir_d = stable;
      if (stable[DIR_UP] && stable[DIR_DOWN]) begin
        if (rank_d[DIR_UP] > rank_d[DIR_DOWN]) dir_d[DIR_DOWN] = 1'b0;
        else                                   dir_d[DIR_UP]   = 1'b0;
      end
      if (stable[DIR_LEFT] && stable[DIR_RIGHT]) begin
        if (rank_d[DIR_LEFT] > rank_d[DIR_RIGHT]) dir_d[DIR_RIGHT] = 1'b0;
        else                                      dir_d[DIR_LEFT]  = 1'b0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (stable[d] && (!found || rank_d[d] > best)) begin
          found    = 1'b1;
          best     = rank_d[d];
          dir_d    = '0;
          dir_d[d] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int d = 0; d < 4; d++) rank_q[d] <= 2'(d);
      prev_q   <= '0;
      dir_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rank_q   <= rank_d;
      prev_q   <= stable;
      dir_q    <= dir_d;
      active_q <= |dir_d;
    end
  end

  assign dir    = dir_q;
  assign active = active_q;

endmodule

// File: rtl/arcade_joy_cond.sv
// Per-player joystick/coin conditioner: sync, ce-qualified debounce, rotation,
// 4/8-way resolution and coin pulse shaping.
module arcade_joy_cond
  import arcade_input_pkg::*;
#(
  parameter int unsigned NPLAYERS = 2,
  parameter int unsigned DEB_CNT  = 4,
  parameter int unsigned COIN_MIN = 8
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  ce,
  input  logic                  mode_8way,
  input  logic                  rotate,
  input  logic [NPLAYERS*4-1:0] joy_in,
  input  logic [NPLAYERS-1:0]   coin_in,
  output logic [NPLAYERS*4-1:0] joy_out,
  output logic [NPLAYERS-1:0]   coin_out,
  output logic [NPLAYERS-1:0]   active
);

  localparam int unsigned CntW = $clog2(DEB_CNT + 1);
  localparam int unsigned TmrW = $clog2(COIN_MIN + 1);

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
    // Bit 4 carries the coin button; bits 3:0 the directions.
    logic [4:0]      sync1_q, sync2_q, stable_q, stable_d, deb_in;
    logic [CntW-1:0] cnt_q [5];
    logic [CntW-1:0] cnt_d [5];
    logic            cprev_q;
    logic [TmrW-1:0] timer_q, timer_d;
    logic            coin_q;

    assign deb_in = {sync2_q[4], rotate ? rot90(sync2_q[3:0]) : sync2_q[3:0]};

    always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (ce) begin
        for (int b = 0; b < 5; b++) begin
          if (deb_in[b] == stable_q[b]) begin
            cnt_d[b] = '0;
          end else if (cnt_q[b] == CntW'(DEB_CNT - 1)) begin
            stable_d[b] = deb_in[b];
            cnt_d[b]    = '0;
          end else begin
            cnt_d[b] = cnt_q[b] + 1'b1;
          end
        end
      end

      timer_d = timer_q;
      if (timer_q != '0) begin
        if (ce) timer_d = timer_q - 1'b1;
      end else if (stable_q[4] && !cprev_q) begin
        timer_d = TmrW'(COIN_MIN);
      end
    end

    always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
        sync1_q  <= '0;
        sync2_q  <= '0;
        stable_q <= '0;
        for (int b = 0; b < 5; b++) cnt_q[b] <= '0;
        cprev_q  <= 1'b0;
        timer_q  <= '0;
        coin_q   <= 1'b0;
      end else begin
        sync1_q  <= {coin_in[p], joy_in[4*p +: 4]};
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
        cprev_q  <= stable_q[4];
        timer_q  <= timer_d;
        coin_q   <= (timer_d != '0);
      end
    end

    joy_dir_prio u_prio (
      .clk       (clk),
      .RESET     (RESET),
      .stable    (stable_q[3:0]),
      .mode_8way (mode_8way),
      .dir       (joy_out[4*p +: 4]),
      .active    (active[p])
    );

    assign coin_out[p] = coin_q;
  end

endmodule

// File: tb/tb_arcade_joy_cond.sv
// Scoreboard bench for arcade_joy_cond: recency-list reference model plus directed scenarios.
module tb_arcade_joy_cond;

  localparam int NP   = 2;
  localparam int DEB  = 4;
  localparam int CMIN = 8;

  logic          clk = 1'b0;
  logic          RESET, ce, mode_8way, rotate;
  logic [NP*4-1:0] joy_in, joy_out;
  logic [NP-1:0] coin_in, coin_out, active;

  int n_cmp = 0;
  int n_fail = 0;

  arcade_joy_cond #(.NPLAYERS(NP), .DEB_CNT(DEB), .COIN_MIN(CMIN)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .ce        (ce),
    .mode_8way (mode_8way),
    .rotate    (rotate),
    .joy_in    (joy_in),
    .coin_in   (coin_in),
    .joy_out   (joy_out),
    .coin_out  (coin_out),
    .active    (active)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [4:0] m_s1 [NP];
  logic [4:0] m_s2 [NP];
  logic [4:0] m_st [NP];
  logic [3:0] m_pv [NP];
  logic [3:0] m_jo [NP];
  logic       m_cpv [NP];
  logic       m_co [NP];
  int         m_cnt [NP][5];
  int         m_tmr [NP];
  int         rec [NP][4];   // directions ordered most-recent-press first
  logic [4*NP+2*NP-1:0] exp_q [$];

  function automatic logic [3:0] rot_ref(input logic [3:0] v);
    logic [3:0] r;
    r[3] = v[1]; r[2] = v[0]; r[1] = v[2]; r[0] = v[3];
    return r;
  endfunction

  function automatic int pos_of(input int p, input int d);
    for (int i = 0; i < 4; i++) if (rec[p][i] == d) return i;
    return 4;
  endfunction

  task automatic model_player(input int p);
    logic [4:0] old_st, dv;
    logic [3:0] rise, held;
    int nl [4];
    int k;
    old_st = m_st[p];
    dv = {m_s2[p][4], rotate ? rot_ref(m_s2[p][3:0]) : m_s2[p][3:0]};
    if (ce) begin
      for (int b = 0; b < 5; b++) begin
        if (dv[b] == m_st[p][b]) m_cnt[p][b] = 0;
        else if (m_cnt[p][b] == DEB - 1) begin
          m_st[p][b] = dv[b];
          m_cnt[p][b] = 0;
        end else m_cnt[p][b]++;
      end
    end
    rise = old_st[3:0] & ~m_pv[p];
    m_pv[p] = old_st[3:0];
    k = 0;
    for (int d = 3; d >= 0; d--) if (rise[d]) begin nl[k] = d; k++; end
    for (int i = 0; i < 4; i++) if (!rise[rec[p][i]]) begin nl[k] = rec[p][i]; k++; end
    for (int i = 0; i < 4; i++) rec[p][i] = nl[i];
    held = old_st[3:0];
    m_jo[p] = '0;
    if (mode_8way) begin
      m_jo[p] = held;
      if (held[3] && held[2]) m_jo[p][pos_of(p, 3) > pos_of(p, 2) ? 3 : 2] = 1'b0;
      if (held[1] && held[0]) m_jo[p][pos_of(p, 1) > pos_of(p, 0) ? 1 : 0] = 1'b0;
    end else begin
      k = 0;
      for (int i = 0; i < 4; i++)
        if (k == 0 && held[rec[p][i]]) begin m_jo[p][rec[p][i]] = 1'b1; k = 1; end
    end
    if (m_tmr[p] != 0) begin
      if (ce) m_tmr[p]--;
    end else if (old_st[4] && !m_cpv[p]) m_tmr[p] = CMIN;
    m_cpv[p] = old_st[4];
    m_co[p] = (m_tmr[p] != 0);
    m_s2[p] = m_s1[p];
    m_s1[p] = {coin_in[p], joy_in[4*p +: 4]};
  endtask

  initial forever begin
    logic [4*NP+2*NP-1:0] e;
    @(posedge clk);
    for (int p = 0; p < NP; p++) begin
      if (RESET) begin
        m_s1[p] = '0; m_s2[p] = '0; m_st[p] = '0; m_pv[p] = '0; m_jo[p] = '0;
        m_cpv[p] = 1'b0; m_co[p] = 1'b0; m_tmr[p] = 0;
        for (int b = 0; b < 5; b++) m_cnt[p][b] = 0;
        rec[p][0] = 3; rec[p][1] = 2; rec[p][2] = 1; rec[p][3] = 0;
      end else model_player(p);
      e[2*NP + 4*p +: 4] = m_jo[p];
      e[NP + p]          = m_co[p];
      e[p]               = |m_jo[p];
    end
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [4*NP+2*NP-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({joy_out, coin_out, active} !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got %h want %h", $time, {joy_out, coin_out, active}, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic drive(input logic [7:0] j, input logic [1:0] c, input int n);
    @(negedge clk);
    joy_in  = j;
    coin_in = c;
    repeat (n - 1) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int waited;
    RESET = 1'b1; ce = 1'b1; mode_8way = 1'b0; rotate = 1'b0;
    joy_in = '0; coin_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_joy", 32'(joy_out), 0);
    chk("reset_coin_act", 32'({coin_out, active}), 0);
    RESET = 1'b0;
    repeat (2) @(negedge clk);

    // Latency: change appears on the 7th edge after the raw press, not the 6th.
    @(negedge clk); joy_in = 8'h02;
    repeat (6) @(negedge clk);
    chk("latency_early", 32'(joy_out[3:0]), 0);
    @(negedge clk);
    chk("latency_on", 32'(joy_out[3:0]), 32'b0010);
    drive(8'h0A, 2'b00, 3);
    drive(8'h02, 2'b00, 12);
    chk("glitch_ignored", 32'(joy_out[3:0]), 32'b0010);

    drive(8'h0A, 2'b00, 10);  chk("4way_up_over_left", 32'(joy_out[3:0]), 32'b1000);
    drive(8'h02, 2'b00, 10);  chk("4way_left_returns", 32'(joy_out[3:0]), 32'b0010);
    drive(8'h00, 2'b00, 10);  chk("4way_none", 32'(joy_out[3:0]), 0);
    chk("active_low", 32'(active[0]), 0);

    drive(8'h09, 2'b00, 10);  chk("tie_up_wins", 32'(joy_out[3:0]), 32'b1000);
    drive(8'h01, 2'b00, 10);  chk("tie_fallback", 32'(joy_out[3:0]), 32'b0001);
    drive(8'h00, 2'b00, 10);

    mode_8way = 1'b1;
    drive(8'h09, 2'b00, 10);  chk("8way_diag", 32'(joy_out[3:0]), 32'b1001);
    drive(8'h0D, 2'b00, 10);  chk("8way_down_wins", 32'(joy_out[3:0]), 32'b0101);
    drive(8'h09, 2'b00, 10);  chk("8way_restore", 32'(joy_out[3:0]), 32'b1001);
    drive(8'h00, 2'b00, 10);
    mode_8way = 1'b0;

    rotate = 1'b1;
    drive(8'h20, 2'b00, 10);  chk("rot_left_to_up", 32'(joy_out[7:4]), 32'b1000);
    drive(8'h80, 2'b00, 10);  chk("rot_up_to_right", 32'(joy_out[7:4]), 32'b0001);
    drive(8'h00, 2'b00, 10);
    rotate = 1'b0;

    // Coin held 100 cycles: one pulse of COIN_MIN cycles.
    cnt = 0;
    @(negedge clk); coin_in = 2'b01;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (coin_out[0]) cnt++;
    end
    chk("coin_len", 32'(cnt), CMIN);
    drive(8'h00, 2'b00, 20);

    // Sparse ce stretches the pulse to about COIN_MIN*4 cycles.
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (coin_out[0]) cnt++;
      ce = (i % 4 == 0);
      coin_in = 2'b01;
    end
    chk("coin_len_sparse_ce", 32'(cnt >= CMIN * 4 - 3 && cnt <= CMIN * 4), 1);
    ce = 1'b1;
    drive(8'h00, 2'b00, 20);

    // Reset mid-pulse clears at once; nothing resumes afterwards.
    @(negedge clk); coin_in = 2'b10;
    waited = 0;
    while (!coin_out[1] && waited < 50) begin @(negedge clk); waited++; end
    chk("coin_pulse_seen", 32'(coin_out[1]), 1);
    repeat (3) @(negedge clk);
    #2 RESET = 1'b1;
    #1 chk("reset_mid_pulse", 32'(coin_out), 0);
    coin_in = '0;
    repeat (3) @(negedge clk);
    #2 RESET = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (coin_out != 0) cnt++;
    end
    chk("no_resume", 32'(cnt), 0);

    // Randomised traffic against the scoreboard.
    for (int it = 0; it < 160; it++) begin
      int hold;
      hold = $urandom_range(1, 12);
      @(negedge clk);
      joy_in  = 8'($urandom & $urandom);
      coin_in = 2'($urandom_range(0, 7) == 0 ? $urandom : 0);
      if ($urandom_range(0, 15) == 0) mode_8way = ~mode_8way;
      if ($urandom_range(0, 23) == 0) rotate = ~rotate;
      for (int c = 0; c < hold; c++) begin
        ce = ($urandom_range(0, 3) != 0);
        if (c != hold - 1) @(negedge clk);
      end
    end
    ce = 1'b1;
    joy_in = '0; coin_in = '0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
